axi_tensor_wr_sink: RTL and testbench

- AXI4 write-slave sink downstream of the tensor-core write-back stage. It accepts the AW/W bursts that stage emits (32 beats in normal mode, 16 in FP16 non-mixed mode).
- Stores each 256-bit beat into an internal beat-addressed memory and returns a B response.
- Provides a registered read-back port and error/beat counters. This lets system benches check the stored result layout without an external DRAM model.

---
 rtl/axi_tensor_wr_sink_if.sv | 32 +++
 rtl/axi_tensor_wr_sink.sv | 119 +++++++++++
 tb/tb_axi_tensor_wr_sink.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_tensor_wr_sink_if.sv
// AXI4 write-channel bundle (AW, W, B) between the tensor write-back master and the sink.
// The sink's ready/response outputs are driven from its registered state, not from master inputs.
interface axi_tensor_wr_sink_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic [7:0]            axi_awlen;
  logic [2:0]            axi_awsize;
  logic [1:0]            axi_awburst;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic                  axi_wlast;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [1:0]            axi_bresp;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    output axi_wvalid, axi_wdata, axi_wlast, axi_bready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    input  axi_wvalid, axi_wdata, axi_wlast, axi_bready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp
  );
endinterface

// File: rtl/axi_tensor_wr_sink.sv
// AXI4 write sink: stores 256-bit beats into a beat-addressed memory, answers with B,
// and exposes a registered read-back port plus beat/error counters.
module axi_tensor_wr_sink #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int MEM_DEPTH  = 64,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_tensor_wr_sink_if.slave   axi,
  input  logic                  stall,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           beats_written,
  output logic                  err_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_base;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_burstErr;
  logic                  r_errFlag;
  logic [15:0]           r_beatsWritten;
  logic [DATA_WIDTH-1:0] r_rdData;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_bHs;
  logic                  w_fmtErr;
  logic                  w_cntHit;
  logic                  w_lastErr;
  logic [IDX_W-1:0]      w_wrIdx;

  assign axi.axi_awready = ~rst & (r_state == S_IDLE);
  assign axi.axi_wready  = ~rst & (r_state == S_DATA) & ~stall;
  assign axi.axi_bvalid  = ~rst & (r_state == S_RESP);
  assign axi.axi_bresp   = (~rst && r_state == S_RESP && r_burstErr) ? 2'b10 : 2'b00;

  assign w_awHs    = axi.axi_awvalid & axi.axi_awready;
  assign w_wHs     = axi.axi_wvalid & axi.axi_wready;
  assign w_bHs     = axi.axi_bvalid & axi.axi_bready;

  // Only 32-byte INCR beats starting on a beat boundary can be stored faithfully.
  assign w_fmtErr  = (axi.axi_awsize != 3'b101) | (axi.axi_awburst != 2'b01) |
                     (axi.axi_awaddr[4:0] != 5'd0);
  assign w_cntHit  = (r_cnt == r_len);
  assign w_lastErr = axi.axi_wlast ^ w_cntHit;
  assign w_wrIdx   = r_base + IDX_W'(r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_burstErr     <= 1'b0;
      r_errFlag      <= 1'b0;
      r_beatsWritten <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_awHs) begin
            r_base     <= axi.axi_awaddr[5 +: IDX_W];
            r_len      <= axi.axi_awlen;
            r_cnt      <= '0;
            r_burstErr <= w_fmtErr;
            r_errFlag  <= r_errFlag | w_fmtErr;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          // The burst length comes from awlen alone; a misplaced wlast only flags an error.
          if (w_wHs) begin
            r_cnt          <= r_cnt + 8'd1;
            r_beatsWritten <= r_beatsWritten + 16'd1;
            r_burstErr     <= r_burstErr | w_lastErr;
            r_errFlag      <= r_errFlag | w_lastErr;
            if (w_cntHit) begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (w_bHs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is deliberately left out of reset so stored results survive a bench reset.
  always_ff @(posedge clk) begin
    if (w_wHs && !r_burstErr) begin
      r_mem[w_wrIdx] <= axi.axi_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= r_mem[rd_addr];
    end
  end

  assign rd_data       = r_rdData;
  assign beats_written = r_beatsWritten;
  assign err_flag      = r_errFlag;

endmodule

// File: tb/tb_axi_tensor_wr_sink.sv
// Directed bench for axi_tensor_wr_sink: hand-computed expectations checked with
// immediate assertions; inputs change on the falling edge, outputs are sampled there too.
module tb_axi_tensor_wr_sink;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 256;
  localparam int MEM_DEPTH  = 64;
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall;
  logic [IDX_W-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [15:0]           beats_written;
  logic                  err_flag;

  int checks = 0;
  int errors = 0;

  axi_tensor_wr_sink_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axi ();

  axi_tensor_wr_sink #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .axi          (axi.slave),
    .stall        (stall),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .beats_written(beats_written),
    .err_flag     (err_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    int guard;
    guard = 0;
    @(negedge clk);
    axi.axi_awvalid = 1'b1;
    axi.axi_awaddr  = addr;
    axi.axi_awlen   = len;
    axi.axi_awsize  = size;
    axi.axi_awburst = burst;
    #1;
    while (!axi.axi_awready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("aw_ready_seen", {255'd0, axi.axi_awready}, 256'd1);
    @(posedge clk);
    @(negedge clk);
    axi.axi_awvalid = 1'b0;
  endtask

  // Sends nBeats W beats; wlast goes high on beat lastIdx (-1 means never).
  task automatic sendBeats(input int nBeats, input int lastIdx, input bit toggleStall,
                           input logic [255:0] dataBase, output int cycles);
    int k;
    k = 0;
    cycles = 0;
    while (k < nBeats && cycles < 500) begin
      axi.axi_wvalid = 1'b1;
      axi.axi_wdata  = dataBase + 256'(k);
      axi.axi_wlast  = (k == lastIdx);
      if (toggleStall) stall = ~stall;
      #1;
      if (toggleStall)
        checkOutput("wready_vs_stall", {255'd0, axi.axi_wready}, {255'd0, ~stall});
      if (axi.axi_wready) k++;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    axi.axi_wvalid = 1'b0;
    axi.axi_wlast  = 1'b0;
    stall          = 1'b0;
    checkOutput("w_beats_accepted", 256'(k), 256'(nBeats));
  endtask

  // Expects B already asserted, checks the response code and completes the handshake.
  task automatic finishResp(input logic [1:0] expResp);
    #1;
    checkOutput("bvalid_after_last", {255'd0, axi.axi_bvalid}, 256'd1);
    checkOutput("bresp", {254'd0, axi.axi_bresp}, {254'd0, expResp});
    axi.axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.axi_bready = 1'b0;
  endtask

  task automatic checkMem(input string tag, input int idx, input logic [255:0] expected);
    @(negedge clk);
    rd_addr = IDX_W'(idx);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag, rd_data, expected);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    stall = 1'b0;
    rd_addr = '0;
    axi.axi_awvalid = 1'b0;
    axi.axi_awaddr  = '0;
    axi.axi_awlen   = '0;
    axi.axi_awsize  = '0;
    axi.axi_awburst = '0;
    axi.axi_wvalid  = 1'b0;
    axi.axi_wdata   = '0;
    axi.axi_wlast   = 1'b0;
    axi.axi_bready  = 1'b0;

    // Reset values, both while held and in the first cycle after release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_awready", {255'd0, axi.axi_awready}, 256'd0);
    checkOutput("rst_wready", {255'd0, axi.axi_wready}, 256'd0);
    checkOutput("rst_bvalid", {255'd0, axi.axi_bvalid}, 256'd0);
    checkOutput("rst_bresp", {254'd0, axi.axi_bresp}, 256'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_awready", {255'd0, axi.axi_awready}, 256'd1);
    checkOutput("post_rst_rd_data", rd_data, 256'd0);
    checkOutput("post_rst_beats", {240'd0, beats_written}, 256'd0);
    checkOutput("post_rst_err", {255'd0, err_flag}, 256'd0);

    $display("[TB] normal 32-beat burst");
    applyStimulus(32'd0, 8'd31, 3'b101, 2'b01);
    sendBeats(32, 31, 1'b0, 256'd0, cyc);
    checkOutput("normal_w_cycles", 256'(cyc), 256'd32);
    finishResp(2'b00);
    checkOutput("normal_beats", {240'd0, beats_written}, 256'd32);
    checkOutput("normal_err", {255'd0, err_flag}, 256'd0);
    checkMem("normal_mem0", 0, 256'd0);
    checkMem("normal_mem5", 5, 256'd5);
    checkMem("normal_mem31", 31, 256'd31);

    $display("[TB] FP16 16-beat burst with toggling stall");
    applyStimulus(32'd0, 8'd15, 3'b101, 2'b01);
    sendBeats(16, 15, 1'b1, 256'd100, cyc);
    finishResp(2'b00);
    checkOutput("fp16_beats", {240'd0, beats_written}, 256'd48);
    checkMem("fp16_mem0", 0, 256'd100);
    checkMem("fp16_mem15", 15, 256'd115);
    checkMem("fp16_mem16_untouched", 16, 256'd16);

    $display("[TB] format error burst then clean burst");
    applyStimulus(32'd0, 8'd7, 3'b100, 2'b01);
    sendBeats(8, 7, 1'b0, 256'hDEAD00, cyc);
    checkOutput("fmt_w_cycles", 256'(cyc), 256'd8);
    finishResp(2'b10);
    checkOutput("fmt_err", {255'd0, err_flag}, 256'd1);
    checkOutput("fmt_beats", {240'd0, beats_written}, 256'd56);
    checkMem("fmt_mem0_kept", 0, 256'd100);
    checkMem("fmt_mem7_kept", 7, 256'd107);
    applyStimulus(32'd1024, 8'd3, 3'b101, 2'b01);
    sendBeats(4, 3, 1'b0, 256'd200, cyc);
    finishResp(2'b00);
    checkOutput("fmt_err_sticky", {255'd0, err_flag}, 256'd1);
    checkMem("clean_mem32", 32, 256'd200);
    checkMem("clean_mem35", 35, 256'd203);

    $display("[TB] early wlast");
    applyReset(1);
    checkOutput("early_pre_err", {255'd0, err_flag}, 256'd0);
    applyStimulus(32'd0, 8'd31, 3'b101, 2'b01);
    sendBeats(32, 15, 1'b0, 256'h400, cyc);
    checkOutput("early_w_cycles", 256'(cyc), 256'd32);
    finishResp(2'b10);
    checkOutput("early_err", {255'd0, err_flag}, 256'd1);

    $display("[TB] missing wlast");
    applyReset(1);
    applyStimulus(32'd0, 8'd31, 3'b101, 2'b01);
    sendBeats(32, -1, 1'b0, 256'h500, cyc);
    finishResp(2'b10);
    checkOutput("miss_err", {255'd0, err_flag}, 256'd1);
    checkOutput("miss_beats", {240'd0, beats_written}, 256'd32);

    $display("[TB] B backpressure with concurrent AW");
    applyReset(1);
    applyStimulus(32'd0, 8'd3, 3'b101, 2'b01);
    sendBeats(4, 3, 1'b0, 256'd700, cyc);
    axi.axi_awvalid = 1'b1;
    axi.axi_awaddr  = 32'd1280;
    axi.axi_awlen   = 8'd0;
    axi.axi_awsize  = 3'b101;
    axi.axi_awburst = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_bvalid_held", {255'd0, axi.axi_bvalid}, 256'd1);
      checkOutput("bp_bresp_held", {254'd0, axi.axi_bresp}, 256'd0);
      checkOutput("bp_awready_low", {255'd0, axi.axi_awready}, 256'd0);
      @(negedge clk);
    end
    axi.axi_bready = 1'b1;
    #1;
    checkOutput("bp_awready_at_bhs", {255'd0, axi.axi_awready}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    axi.axi_bready = 1'b0;
    #1;
    checkOutput("bp_bvalid_cleared", {255'd0, axi.axi_bvalid}, 256'd0);
    checkOutput("bp_awready_after", {255'd0, axi.axi_awready}, 256'd1);
    @(posedge clk);
    @(negedge clk);
    axi.axi_awvalid = 1'b0;
    sendBeats(1, 0, 1'b0, 256'h77, cyc);
    finishResp(2'b00);
    checkMem("bp_mem40", 40, 256'h77);
    checkMem("bp_mem3", 3, 256'd703);

    $display("[TB] wrap at end of memory");
    applyStimulus((MEM_DEPTH - 4) * 32, 8'd7, 3'b101, 2'b01);
    sendBeats(8, 7, 1'b0, 256'd300, cyc);
    finishResp(2'b00);
    checkMem("wrap_mem60", 60, 256'd300);
    checkMem("wrap_mem63", 63, 256'd303);
    checkMem("wrap_mem0", 0, 256'd304);
    checkMem("wrap_mem3", 3, 256'd307);

    $display("[TB] reset mid-burst");
    applyStimulus(32'd0, 8'd31, 3'b101, 2'b01);
    sendBeats(10, -1, 1'b0, 256'd500, cyc);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_awready", {255'd0, axi.axi_awready}, 256'd1);
    checkOutput("midrst_wready", {255'd0, axi.axi_wready}, 256'd0);
    checkOutput("midrst_bvalid", {255'd0, axi.axi_bvalid}, 256'd0);
    checkOutput("midrst_beats", {240'd0, beats_written}, 256'd0);
    checkMem("midrst_mem9_kept", 9, 256'd509);
    applyStimulus(32'd0, 8'd3, 3'b101, 2'b01);
    sendBeats(4, 3, 1'b0, 256'd600, cyc);
    finishResp(2'b00);
    checkOutput("after_rst_beats", {240'd0, beats_written}, 256'd4);
    checkMem("after_rst_mem2", 2, 256'd602);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
